// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader in front of the core's instruction ROM.
// Host word writes land in a small FIFO and are drained into the ROM write
// port. The core is held in reset until a load has completed.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   bus_wr/addr/wdata        host write strobe, byte address, data
//   bus_ready                a data write can be accepted this cycle
//   rom_we/waddr/wdata       ROM write request (held until rom_ready)
//   rom_ready                ROM accepts the write this cycle
//   core_reset_n             core reset, high only in RUN
//   loading                  high in LOAD and DRAIN
//   words_loaded             ROM handshakes since load start (saturating)
//   err                      sticky write error, cleared on load start
module prog_loader #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] CTRL_ADDR   = 32'hF000_0000,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          bus_wr,
  input  logic [31:0]   bus_addr,
  input  logic [31:0]   bus_wdata,
  output logic          bus_ready,
  output logic          rom_we,
  input  logic          rom_ready,
  output logic [AW-1:0] rom_waddr,
  output logic [31:0]   rom_wdata,
  output logic          core_reset_n,
  output logic          loading,
  output logic [AW:0]   words_loaded,
  output logic          err
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [32:0] WIN_BYTES = 33'(4 * DEPTH_WORDS);
  localparam logic [AW:0] WL_MAX    = (AW+1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {HALT, LOAD, DRAIN, RUN} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } entry_t;

  state_t        state, nxt;
  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          full, empty;

  // Bus decode
  logic        ctrl_hit, start, go;
  logic [31:0] off;
  logic        in_win, data_hit, push, bad, hs;

  assign ctrl_hit = bus_wr && (bus_addr == CTRL_ADDR);
  assign start    = ctrl_hit && bus_wdata[0];
  assign go       = ctrl_hit && !bus_wdata[0] && bus_wdata[1];

  // Window test on the offset: addresses below BASE_ADDR wrap to huge offsets.
  assign off      = bus_addr - BASE_ADDR;
  assign in_win   = ({1'b0, off} < WIN_BYTES);
  assign data_hit = bus_wr && !ctrl_hit && in_win && (off[1:0] == 2'b00);

  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign bus_ready = (state == LOAD) && !full;

  assign push = data_hit && bus_ready;
  // Any non-control write that is not pushed is an error (bad address,
  // misaligned, or refused for lack of bus_ready).
  assign bad  = bus_wr && !ctrl_hit && !push;

  // The FIFO head drives the ROM port directly; head and count are registers.
  assign rom_we    = !empty;
  assign rom_waddr = mem[rd_ptr].addr;
  assign rom_wdata = mem[rd_ptr].data;
  assign hs        = rom_we && rom_ready;

  // FIFO storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{addr: off[AW+1:2], data: bus_wdata};
    end
  end

  // FIFO pointers; start-load flushes and drops any pending ROM write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (start) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (hs)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(hs);
    end
  end

  // Next state
  always_comb begin
    nxt = state;
    if (start)                        nxt = LOAD;
    else if (go && state == LOAD)     nxt = DRAIN;
    else if (state == DRAIN && empty) nxt = RUN;
  end

  // State and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HALT;
      core_reset_n <= 1'b0;
      loading      <= 1'b0;
      words_loaded <= '0;
      err          <= 1'b0;
    end else begin
      state        <= nxt;
      // Release one cycle after entering RUN; drop as soon as RUN is left.
      core_reset_n <= (state == RUN) && (nxt == RUN);
      loading      <= (nxt == LOAD) || (nxt == DRAIN);
      if (start)
        words_loaded <= '0;
      else if (hs && words_loaded != WL_MAX)
        words_loaded <= words_loaded + 1'b1;
      if (start)    err <= 1'b0;
      else if (bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised + directed bench for prog_loader with a queue-based reference
// model and a scoreboard monitor on the ROM write port.
module tb_prog_loader;
  localparam int          DW   = 16;
  localparam int          FD   = 4;
  localparam int          AW   = $clog2(DW);
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] CTRL = 32'hF000_0000;

  logic          clk, reset_n;
  logic          bus_wr, bus_ready, rom_we, rom_ready, core_reset_n, loading, err;
  logic [31:0]   bus_addr, bus_wdata, rom_wdata;
  logic [AW-1:0] rom_waddr;
  logic [AW:0]   words_loaded;

  prog_loader #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD), .BASE_ADDR(BASE), .CTRL_ADDR(CTRL)) dut (
    .clk(clk), .reset_n(reset_n), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .rom_we(rom_we),
    .rom_ready(rom_ready), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .core_reset_n(core_reset_n), .loading(loading),
    .words_loaded(words_loaded), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;
  typedef enum {M_HALT, M_LOAD, M_DRAIN, M_RUN} mode_e;

  wr_t   pend[$];   // model of words waiting for the ROM
  wr_t   exp_q[$];  // scoreboard of expected ROM writes
  mode_e mode;
  bit    m_crn, m_err;
  int    m_wl;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a handshake happens at the coming edge.
  always @(negedge clk) begin
    if (reset_n && rom_we === 1'b1 && rom_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rom_write: addr %h data %h at %0t", rom_waddr, rom_wdata, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_addr", 32'(rom_waddr), 32'(e.a));
        chk("sb_data", rom_wdata, e.d);
      end
    end
  end

  // One cycle: drive inputs, check pre-edge outputs, advance model, check status.
  task automatic step(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit rr);
    int    sz;
    bit    bready;
    mode_e old;
    logic [31:0] o;
    bus_wr = wr; bus_addr = a; bus_wdata = d; rom_ready = rr;
    sz     = pend.size();
    bready = (mode == M_LOAD) && (sz < FD);
    chk("bus_ready", 32'(bus_ready), 32'(bready));
    chk("rom_we", 32'(rom_we), 32'(sz > 0));
    if (sz > 0) begin
      chk("rom_waddr_head", 32'(rom_waddr), 32'(pend[0].a));
      chk("rom_wdata_head", rom_wdata, pend[0].d);
    end
    @(posedge clk);
    old = mode;
    if (sz > 0 && rr) begin
      void'(pend.pop_front());
      if (m_wl < DW) m_wl++;
    end
    if (wr && a == CTRL && d[0]) begin
      mode = M_LOAD;
      pend.delete();
      exp_q.delete();
      m_wl  = 0;
      m_err = 0;
    end else begin
      if (wr && a != CTRL) begin
        o = a - BASE;
        if (o < 4 * DW && o[1:0] == 2'b00 && bready) begin
          pend.push_back('{a: AW'(o >> 2), d: d});
          exp_q.push_back('{a: AW'(o >> 2), d: d});
        end else begin
          m_err = 1;
        end
      end
      if (wr && a == CTRL && d[1] && mode == M_LOAD) mode = M_DRAIN;
      else if (mode == M_DRAIN && sz == 0)           mode = M_RUN;
    end
    m_crn = (old == M_RUN) && (mode == M_RUN);
    #1;
    chk("core_reset_n", 32'(core_reset_n), 32'(m_crn));
    chk("loading", 32'(loading), 32'(mode == M_LOAD || mode == M_DRAIN));
    chk("words_loaded", 32'(words_loaded), 32'(m_wl));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0, rr);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus_wr  = 1'b0;
    #1;
    chk("rst_rom_we", 32'(rom_we), 32'h0);
    chk("rst_rom_waddr", 32'(rom_waddr), 32'h0);
    chk("rst_rom_wdata", rom_wdata, 32'h0);
    chk("rst_core_reset_n", 32'(core_reset_n), 32'h0);
    chk("rst_loading", 32'(loading), 32'h0);
    chk("rst_bus_ready", 32'(bus_ready), 32'h0);
    chk("rst_words_loaded", 32'(words_loaded), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    mode = M_HALT; pend.delete(); exp_q.delete();
    m_wl = 0; m_err = 0; m_crn = 0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int r;
    reset_n = 1'b1; bus_wr = 0; bus_addr = 0; bus_wdata = 0; rom_ready = 0;
    #2;
    do_reset();

    // Basic load of three words, then run
    step(1, CTRL, 32'h1, 1);
    step(1, BASE + 32'h0, 32'h13, 1);
    step(1, BASE + 32'h4, 32'h93, 1);
    step(1, BASE + 32'h8, 32'h6F, 1);
    step(1, CTRL, 32'h2, 1);
    idle(5, 1);

    // Back-pressure: FIFO fills, further writes refused with err
    step(1, CTRL, 32'h1, 0);
    for (int i = 0; i < 10; i++) step(1, BASE + 32'(4 * i), $urandom, 0);
    idle(6, 1);

    // Bad addresses in LOAD, then a no-op control write
    step(1, CTRL, 32'h1, 1);
    step(1, 32'h8000_4000, 32'h1, 1);
    step(1, 32'h8000_0002, 32'h2, 1);
    step(1, BASE + 32'(4 * DW), 32'h3, 1);
    step(1, 32'h7FFF_FFFC, 32'h4, 1);
    step(1, BASE + 32'(4 * DW - 4), 32'h5, 1);
    step(1, CTRL, 32'h0, 1);
    step(1, CTRL, 32'h2, 1);
    idle(4, 1);

    // In RUN: data write refused, then start-load
    step(1, BASE, 32'hAA, 1);
    step(1, CTRL, 32'h3, 1);
    idle(2, 1);

    // Go with pending words, writes during DRAIN refused
    step(1, BASE + 32'h10, 32'hB0, 0);
    step(1, BASE + 32'h14, 32'hB1, 0);
    step(1, CTRL, 32'h2, 0);
    step(1, BASE + 32'h18, 32'hB2, 0);
    step(1, BASE + 32'h1C, 32'hB3, 0);
    idle(3, 0);
    idle(6, 1);

    // Reset with two words pending
    step(1, CTRL, 32'h1, 0);
    step(1, BASE + 32'h20, 32'hC0, 0);
    step(1, BASE + 32'h24, 32'hC1, 0);
    do_reset();
    idle(4, 1);

    // Saturation of words_loaded
    step(1, CTRL, 32'h1, 1);
    for (int i = 0; i < DW + 4; i++) step(1, BASE + 32'(4 * (i % DW)), 32'(i * 7 + 1), 1);
    step(1, CTRL, 32'h2, 1);
    idle(4, 1);

    // Random traffic
    step(1, CTRL, 32'h1, 1);
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      step(1, BASE + 32'(4 * $urandom_range(0, DW - 1)), $urandom, $urandom_range(0, 9) < 7);
      else if (r < 68) step(1, BASE + 32'($urandom_range(0, 4 * DW + 8)), $urandom, $urandom_range(0, 1));
      else if (r < 70) step(1, CTRL, 32'h1 | 32'($urandom_range(0, 3)), $urandom_range(0, 1));
      else if (r < 74) step(1, CTRL, 32'h2, $urandom_range(0, 1));
      else             step(0, 32'h0, 32'h0, $urandom_range(0, 9) < 7);
    end
    idle(10, 1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
